// File: rtl/stall_buffer_feeder.sv
// stall_buffer_feeder
// Credit-based write-side controller for the two-slot pipeline stall buffer.
// Upstream words enter a one-entry holding register through a valid/ready
// handshake. A held word is written into the stall buffer (enq) only while a
// credit for a free slot is held. Credits return on deq_seen, and flush
// resets the feeder together with the buffer.
// Optional build macro: FEEDER_STATS_EN adds stall_cycles / issued_count.

module stall_buffer_feeder #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             deq_seen,
    output logic             enq,
    output logic [WIDTH-1:0] enq_data,
    output logic [CW-1:0]    credits,
    output logic             stall,
    output logic             err_overflow
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      issued_count
`endif
);

    localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ISSUE,
        S_STALLED
    } state_t;

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    state_t           state;

    // Decode the feeder state from the holding register and credit count.
    always_comb begin
        // NOTE: default first so every path assigns state and no latch is inferred.
        state = S_EMPTY;
        if (hold_valid) begin
            state = (credits != '0) ? S_ISSUE : S_STALLED;
        end
    end

    // Handshake outputs; flush masks issue and accept in the same cycle.
    // deq_seen is deliberately absent here so a returned credit is only
    // usable from the following cycle.
    always_comb begin
        enq      = (state == S_ISSUE) && !flush;
        enq_data = hold_data;
        in_ready = !flush && (!hold_valid || enq);
        stall    = (state == S_STALLED);
    end

    // Holding register, credit counter and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            // NOTE: hold_data is a single word, so it is reset like any other
            // register; it is not a memory array.
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            credits      <= FULL_CREDITS;
            err_overflow <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            credits    <= FULL_CREDITS;
        end else begin
            // Loading has priority: a word accepted while the old one issues
            // replaces it and keeps hold_valid set.
            if (in_valid && in_ready) begin
                hold_data  <= in_data;
                hold_valid <= 1'b1;
            end else if (enq) begin
                hold_valid <= 1'b0;
            end

            // A dequeue reported with every credit already home cannot be
            // real: keep the count at DEPTH and latch the error.
            if (deq_seen && !enq && (credits == FULL_CREDITS)) begin
                err_overflow <= 1'b1;
            end else begin
                credits <= credits - CW'(enq) + CW'(deq_seen);
            end
        end
    end

`ifdef FEEDER_STATS_EN
    // Statistics counters; cleared by reset only, flush leaves them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            issued_count <= '0;
        end else begin
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (enq) begin
                issued_count <= issued_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stall_buffer_feeder.sv
// tb_stall_buffer_feeder
// Directed bench for stall_buffer_feeder. A queue-based model tracks the held
// word and the credit pool; a negedge process compares every output against
// it, and literal expectations pin the model at the key points of each
// scenario.

module tb_stall_buffer_feeder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             deq_seen;
    logic             enq;
    logic [WIDTH-1:0] enq_data;
    logic [CW-1:0]    credits;
    logic             stall;
    logic             err_overflow;
`ifdef FEEDER_STATS_EN
    logic [15:0]      stall_cycles;
    logic [15:0]      issued_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: at most one held word, an integer credit pool.
    logic [WIDTH-1:0] m_q[$];
    int               m_cred;
    bit               m_err;
    int               m_stall_cnt;
    int               m_issued;

    stall_buffer_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .deq_seen     (deq_seen),
        .enq          (enq),
        .enq_data     (enq_data),
        .credits      (credits),
        .stall        (stall),
        .err_overflow (err_overflow)
`ifdef FEEDER_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .issued_count (issued_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_enq();
        return (m_q.size() != 0) && (m_cred > 0) && !flush;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_cred      = DEPTH;
        m_err       = 1'b0;
        m_stall_cnt = 0;
        m_issued    = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented.
    task automatic m_update();
        bit e;
        bit rdy;
        bit st;
        e   = m_enq();
        st  = (m_q.size() != 0) && (m_cred == 0);
        rdy = (m_q.size() == 0) || e;
        if (st && m_stall_cnt < 65535) m_stall_cnt++;
        if (e) m_issued = (m_issued + 1) % 65536;
        if (flush) begin
            m_q.delete();
            m_cred = DEPTH;
        end else begin
            if (e) void'(m_q.pop_front());
            if (in_valid && rdy) m_q.push_back(in_data);
            if (deq_seen && !e && m_cred == DEPTH) m_err = 1'b1;
            else m_cred = m_cred - int'(e) + int'(deq_seen);
        end
    endtask

    // Compare every output with the model once per cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("enq", 64'(enq), 64'(m_enq()));
            check("in_ready", 64'(in_ready), 64'(!flush && (m_q.size() == 0 || m_enq())));
            check("stall", 64'(stall), 64'(m_q.size() != 0 && m_cred == 0));
            check("credits", 64'(credits), 64'(m_cred));
            check("err_overflow", 64'(err_overflow), 64'(m_err));
            if (m_q.size() != 0) check("enq_data", 64'(enq_data), 64'(m_q[0]));
`ifdef FEEDER_STATS_EN
            check("stall_cycles", 64'(stall_cycles), 64'(m_stall_cnt));
            check("issued_count", 64'(issued_count), 64'(m_issued));
`endif
        end
    end

    task automatic set(input logic v, input logic [WIDTH-1:0] d, input logic dq, input logic fl);
        in_valid = v;
        in_data  = d;
        deq_seen = dq;
        flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic dq, input logic fl);
        set(v, d, dq, fl);
        step();
    endtask

    initial begin
        reset = 1'b1;
        set(1'b0, '0, 1'b0, 1'b0);
        m_reset();
        #12 reset = 1'b0;
        #1;
        chk_en = 1'b1;

        // Reset state.
        check("rst_enq", 64'(enq), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_credits", 64'(credits), 64'd2);
        check("rst_err", 64'(err_overflow), 64'd0);

        // Stream 0x11, 0x22, 0x33 with no dequeues.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        set(1'b1, 32'h22, 1'b0, 1'b0);
        #1;
        check("s1_enq", 64'(enq), 64'd1);
        check("s1_data", 64'(enq_data), 64'h11);
        step();
        set(1'b1, 32'h33, 1'b0, 1'b0);
        #1;
        check("s2_enq", 64'(enq), 64'd1);
        check("s2_data", 64'(enq_data), 64'h22);
        step();
        set(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("stalled_credits", 64'(credits), 64'd0);
        check("stalled_stall", 64'(stall), 64'd1);
        check("stalled_data", 64'(enq_data), 64'h33);
        check("stalled_in_ready", 64'(in_ready), 64'd0);
        check("stalled_enq", 64'(enq), 64'd0);

        // One dequeue releases the stalled word on the following cycle.
        set(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("deq_no_comb_enq", 64'(enq), 64'd0);
        step();
        set(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("release_enq", 64'(enq), 64'd1);
        check("release_data", 64'(enq_data), 64'h33);
        check("release_stall", 64'(stall), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        step();
        check("release_credits_after", 64'(credits), 64'd0);

        // Return both credits, then a sustained stream with a dequeue every
        // cycle after the first issue: credits settle at 1.
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, 32'hA0, 1'b0, 1'b0);
        drive(1'b1, 32'hA1, 1'b0, 1'b0);
        for (int i = 2; i < 10; i++) begin
            set(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
            #1;
            check("sustain_credits", 64'(credits), 64'd1);
            check("sustain_enq", 64'(enq), 64'd1);
            check("sustain_data", 64'(enq_data), 64'(32'hA0 + 32'(i - 1)));
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("drained_credits", 64'(credits), 64'd2);

        // Flush while 0xAB is held with no credits.
        drive(1'b1, 32'h01, 1'b0, 1'b0);
        drive(1'b1, 32'h02, 1'b0, 1'b0);
        drive(1'b1, 32'hAB, 1'b0, 1'b0);
        set(1'b1, 32'hCD, 1'b1, 1'b1);
        #1;
        check("flush_enq", 64'(enq), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        set(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("post_flush_credits", 64'(credits), 64'd2);
        check("post_flush_stall", 64'(stall), 64'd0);
        check("post_flush_enq", 64'(enq), 64'd0);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);

        // Spurious dequeue with all credits home.
        drive(1'b0, '0, 1'b1, 1'b0);
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_credits", 64'(credits), 64'd2);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("ovf_sticky", 64'(err_overflow), 64'd1);

        // Asynchronous reset while a word is being issued.
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        set(1'b1, 32'h66, 1'b0, 1'b0);
        #1;
        check("pre_reset_enq", 64'(enq), 64'd1);
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        check("areset_enq", 64'(enq), 64'd0);
        check("areset_credits", 64'(credits), 64'd2);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_err", 64'(err_overflow), 64'd0);
`ifdef FEEDER_STATS_EN
        check("areset_stall_cycles", 64'(stall_cycles), 64'd0);
        check("areset_issued_count", 64'(issued_count), 64'd0);
`endif
        set(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stall_buffer_feeder.md
# stall_buffer_feeder

Credit-based write-side controller for the two-slot pipeline stall buffer. It accepts instruction words from the upstream stage with a valid/ready handshake and holds each word in a one-entry register. It issues `enq` pulses into the stall buffer only while it holds a credit for a free slot. Credits come back when the buffer reports an actual dequeue, and a pipeline flush resets the feeder and the buffer together.

## Interface
- `WIDTH`, default 32: data word width.
- `DEPTH`, default 2: downstream buffer slot count; also the initial credit count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `flush`  in  1  synchronous pipeline flush; the same pulse also drives the buffer's flush.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_ready`  out  1  feeder accepts `in_data` this cycle.
- `deq_seen`  in  1  the downstream buffer performed a dequeue this cycle; asserted only for a real dequeue.
- `enq`  out  1  write `enq_data` into the buffer this cycle.
- `enq_data`  out  WIDTH  word being written.
- `credits`  out  $clog2(DEPTH+1)  free slots known to the feeder.
- `stall`  out  1  a word is held and no credit is available.
- `err_overflow`  out  1  sticky flag: `deq_seen` arrived while credits already equalled DEPTH.

## Operation
- The feeder holds state in these registers:
  - `hold_valid`, `hold_data` (the one-entry holding register);
  - `credits`;
  - `err_overflow`.
- States are derived from the registers:
  - EMPTY: `hold_valid`=0.
  - ISSUE: `hold_valid`=1 and `credits`>0.
  - STALLED: `hold_valid`=1 and `credits`=0.
- The combinational outputs depend only on registers and `flush`:
  - `enq` = `hold_valid` & (`credits`!=0) & !`flush`.
  - `enq_data` = `hold_data`.
  - `in_ready` = !`flush` & (!`hold_valid` | `enq`).
  - `stall` = `hold_valid` & (`credits`==0).
- Register update when `flush`=1:
  - `hold_valid`←0, `hold_data`←0, `credits`←DEPTH.
  - `err_overflow` is unchanged.
  - `in_data` and `deq_seen` are ignored that cycle.
- Holding register update when `flush`=0:
  - If `in_valid` & `in_ready`: `hold_data`←`in_data`, `hold_valid`←1.
  - Else if `enq`: `hold_valid`←0.
  - Otherwise the holding register is unchanged.
- Credit update when `flush`=0:
  - `credits`←`credits` − `enq` + `deq_seen`. A simultaneous enq and deq_seen leaves the count unchanged.
  - If `deq_seen`=1, `enq`=0 and `credits`=DEPTH, the count stays DEPTH and `err_overflow`←1.
- A credit returned by `deq_seen` in cycle N is first usable for `enq` in cycle N+1. There is no combinational path from `deq_seen` to `enq`.
- `enq` can never fire at `credits`=0, so the feeder never writes into a full buffer.
- Reset values:
  - `hold_valid`=0, `hold_data`=0, `credits`=DEPTH, `err_overflow`=0.
  - Resulting outputs: `enq`=0, `in_ready`=1, `stall`=0.

## Timing
- Latency: a word accepted at edge N drives `enq`/`enq_data` in cycle N+1 if `credits`>0 after edge N.
- Throughput is one word per cycle while credits are nonzero. Accept and issue happen in the same cycle: the held word leaves while the new word is loaded.
- STALLED exits one cycle after a `deq_seen` pulse.
- Reset mid-operation clears all state immediately. `enq` drops without waiting for a clock edge.
- `flush` has priority over accept, issue and credit return. While `flush` is high, `enq` and `in_ready` are forced to 0 in the same cycle.

## Configuration
- `FEEDER_STATS_EN` defined:
  - Adds output `stall_cycles [15:0]`, which increments every cycle that `stall`=1 and saturates at 16'hFFFF.
  - Adds output `issued_count [15:0]`, which increments on each `enq` and wraps.
  - Both counters clear on reset only; `flush` does not clear them.
- `FEEDER_STATS_EN` undefined: neither port exists and no counter logic is instantiated.

## Test plan
- Reset then stream 0x11, 0x22, 0x33 on consecutive cycles with no `deq_seen` -> `enq` carries 0x11 and 0x22 one cycle after each accept. Then `credits`=0 and `stall`=1 with 0x33 held, and `in_ready`=0.
- From that STALLED state, pulse `deq_seen` once -> the next cycle `enq`=1 with 0x33, `credits` returns to 0, `stall`=0 and `in_ready`=1.
- Run a sustained stream with `deq_seen` asserted every cycle after the first enq -> `credits` stays at 1, one `enq` per cycle, never `stall`.
- Assert `flush` while holding 0xAB with `credits`=0 -> `enq`=0 and `in_ready`=0 that cycle. Next cycle `credits`=2, `hold_valid`=0, and 0xAB is never issued.
- Pulse `deq_seen` at `credits`=2 -> `err_overflow`=1 and stays set; `credits` remains 2.
- Assert `reset` asynchronously mid-stream while `enq`=1 -> `enq` drops immediately, `credits`=2, `in_ready`=1. With FEEDER_STATS_EN defined, both counters read 0.
